// File: rtl/unrank_seq.sv
// unrank_seq: walks a registered lookup table from column K-1 down to 0,
// subtracting each returned cell value from the remaining rank and emitting
// the returned row as one element of a valid/ready stream.
//
// Optional feature macro: UNRANK_SEQ_CYCLES_EN adds a saturating 16-bit
// 'cycles' output counting clocks from the accept edge to the final
// element handshake (inclusive). Without the macro there is no counter.
//
// Handshake rule for both ports: a transfer happens on the rising clock
// edge where valid and ready are both high. A producer that raises valid
// keeps valid and its payload stable until that edge; ready may be raised
// at any time and has no effect while valid is low.
module unrank_seq #(
  parameter int NUM_WIDTH   = 10,
  parameter int VALUE_WIDTH = 10,
  parameter int COL_WIDTH   = 4,
  parameter int ROW_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_WIDTH-1:0]   in_rank,
  input  logic [COL_WIDTH-1:0]   in_k,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ROW_WIDTH-1:0]   out_elem,
  output logic                   out_last,
  output logic                   err,
  output logic [NUM_WIDTH-1:0]   tbl_num,
  output logic [COL_WIDTH-1:0]   tbl_col,
  input  logic [ROW_WIDTH-1:0]   tbl_row,
  input  logic [VALUE_WIDTH-1:0] tbl_val,
`ifdef UNRANK_SEQ_CYCLES_EN
  output logic [15:0]            cycles,
`endif
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOKUP  = 2'd1,
    S_CAPTURE = 2'd2,
    S_EMIT    = 2'd3
  } state_t;

  state_t                 r_state;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_out_last;
  logic [ROW_WIDTH-1:0]   r_out_elem;
  logic                   r_err;
  logic [NUM_WIDTH-1:0]   r_rem;
  logic [COL_WIDTH-1:0]   r_col;

  logic [NUM_WIDTH-1:0]   w_val_ext;
  logic [NUM_WIDTH-1:0]   w_rem_next;
  logic                   w_val_over;

  // Table value widened to the remainder width; subtraction wraps modulo 2^NUM_WIDTH.
  assign w_val_ext  = NUM_WIDTH'(tbl_val);
  assign w_rem_next = r_rem - w_val_ext;
  assign w_val_over = (w_val_ext > r_rem);

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_elem  = r_out_elem;
  assign err       = r_err;
  assign tbl_num   = r_rem;
  assign tbl_col   = r_col;
  assign dbg_state = r_state;

  // Sequencer FSM: accept request, then per column LOOKUP -> CAPTURE -> EMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_elem  <= '0;
      r_err       <= 1'b0;
      r_rem       <= '0;
      r_col       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_err <= 1'b0;
            r_rem <= in_rank;
            // An empty request (K=0) is consumed without leaving IDLE.
            if (in_k != '0) begin
              r_col      <= in_k - COL_WIDTH'(1);
              r_in_ready <= 1'b0;
              r_state    <= S_LOOKUP;
            end
          end
        end
        S_LOOKUP: begin
          // tbl_num/tbl_col are held here so the table registers them at this edge.
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_out_elem  <= tbl_row;
          r_out_valid <= 1'b1;
          r_out_last  <= (r_col == '0);
          r_rem       <= w_rem_next;
          if (w_val_over) begin
            r_err <= 1'b1;
          end
          r_state <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_col == '0) begin
              r_in_ready <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_col   <= r_col - COL_WIDTH'(1);
              r_state <= S_LOOKUP;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UNRANK_SEQ_CYCLES_EN
  logic [15:0] r_cycles;

  assign cycles = r_cycles;

  // Busy-time counter: cleared on accept, counts every non-IDLE edge, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycles <= '0;
    end else if (r_state == S_IDLE) begin
      if (in_valid) begin
        r_cycles <= '0;
      end
    end else if (r_cycles != 16'hFFFF) begin
      r_cycles <= r_cycles + 16'd1;
    end
  end
`endif

endmodule
